// File: rtl/data_mem_ctrl.sv
// Data-memory controller: owns the word-addressed RAM, posts writes in one cycle and returns
// reads after READ_LAT cycles while stalling the core. Optional DMEM_ALIGN_CHECK_EN flags
// misaligned accesses.
module data_mem_ctrl #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWrite,
    input  logic [31:0] memAddr,
    input  logic [31:0] memwriteData,
    output logic [31:0] data_DataMem,
    output logic        rdValid,
    output logic        stall,
    output logic        alignErr
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          misalign;
    logic          wr_en;
    logic          unused_addr;

    assign idx = memAddr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign    = memCe & (memAddr[1:0] != 2'b00);
    assign unused_addr = ^memAddr[31:AW+2];
`else
    assign misalign    = 1'b0;
    assign unused_addr = ^{memAddr[31:AW+2], memAddr[1:0]};
`endif

    assign alignErr = misalign & ~rst;

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= memwriteData;
        end
    end

    if (READ_LAT == 0) begin : g_comb
        always_comb begin
            wr_en        = ~rst & memCe & memWrite & ~misalign;
            rdValid      = ~rst & memCe & ~memWrite;
            stall        = 1'b0;
            data_DataMem = (rdValid && !misalign) ? mem[idx] : 32'h0;
        end
    end else begin : g_fsm
        typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

        localparam logic [2:0] LatM1 = 3'(READ_LAT - 1);

        state_e        state_q, state_d;
        logic [2:0]    cnt_q, cnt_d;
        logic [AW-1:0] idx_q, idx_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StIdle;
                cnt_q   <= 3'd0;
                idx_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                idx_q   <= idx_d;
            end
        end

        always_comb begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            idx_d        = idx_q;
            wr_en        = 1'b0;
            stall        = 1'b0;
            rdValid      = 1'b0;
            data_DataMem = 32'h0;
            case (state_q)
                StIdle: begin
                    if (memCe) begin
                        if (memWrite) begin
                            wr_en = ~misalign;
                        end else if (misalign) begin
                            rdValid = 1'b1;
                        end else begin
                            idx_d   = idx;
                            cnt_d   = LatM1;
                            stall   = 1'b1;
                            state_d = (READ_LAT == 1) ? StDone : StWait;
                        end
                    end
                end
                StWait: begin
                    // Inputs are ignored here, so a write issued during stall is dropped.
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    rdValid      = 1'b1;
                    data_DataMem = mem[idx_q];
                    state_d      = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
            if (rst) begin
                wr_en        = 1'b0;
                stall        = 1'b0;
                rdValid      = 1'b0;
                data_DataMem = 32'h0;
            end
        end
    end

endmodule
